// File: rtl/clock_div_prog.sv
// ----------------------------------------------------------------------------
// clock_div_prog
//   Programmable integer-N clock divider with a glitch-free runtime divisor
//   change over a req/ack handshake. Even N gives 50% duty directly; odd N
//   gives 50% duty by ANDing the posedge phase with a negedge-delayed copy.
//   N = 0 or N = 1 bypasses the divider and passes clk through a gate whose
//   select only moves while clk is low.
//
// Ports
//   clk      in   source clock
//   resetb   in   asynchronous active-low reset
//   enable   in   1 = run; 0 = stop (low) at the next period boundary
//   div_req  in   request to load div_val; held until div_ack
//   div_val  in   requested divisor, stable while div_req is high
//   div_ack  out  one-cycle pulse in the cycle the new divisor takes effect
//   cur_div  out  divisor currently applied
//   clk_out  out  divided (or bypassed) clock
//   tick     out  one-clk pulse in the cycle where clk_out rises (divide mode)
//   running  out  1 while in RUN or BYP
//
// SIZE must be >= 2; RESET_DIV must be in 2 .. 2**SIZE-1.
// ----------------------------------------------------------------------------
module clock_div_prog #(
  parameter int SIZE      = 8,
  parameter int RESET_DIV = 2
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            enable,
  input  logic            div_req,
  input  logic [SIZE-1:0] div_val,
  output logic            div_ack,
  output logic [SIZE-1:0] cur_div,
  output logic            clk_out,
  output logic            tick,
  output logic            running
);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    BYP  = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

  state_t          state;
  logic [SIZE-1:0] cnt;
  logic            hi_p;       // high-phase flag, posedge domain
  logic            hi_n;       // hi_p delayed half a cycle (negedge)
  logic            byp_sel;    // bypass gate select, negedge domain
  logic            stop_pend;  // enable was seen low during this period

  // (N+1)/2 in SIZE+1 bits so N = 2**SIZE-1 does not overflow.
  logic [SIZE:0]   half;
  logic            wrap;
  logic            upd;
  logic [SIZE-1:0] n_next;
  logic            n_byp;
  logic            stop_now;

  assign half     = ({1'b0, cur_div} + {{SIZE{1'b0}}, 1'b1}) >> 1;
  assign wrap     = (state == RUN) && (cnt == cur_div - ONE);

  // A request is accepted only at a period boundary in RUN, or at any edge in
  // STOP/BYP. The ack cycle itself is ignored so a request still held high
  // after ack is seen as a fresh request one cycle later.
  assign upd      = div_req && !div_ack && ((state != RUN) || wrap);
  assign n_next   = upd ? div_val : cur_div;
  assign n_byp    = (n_next[SIZE-1:1] == '0);
  assign stop_now = stop_pend || !enable;

  assign running  = (state != STOP);

  // Divided output: even N uses hi_p directly, odd N trims half a cycle off
  // the front of the high phase with hi_n. hi_p is forced low outside RUN, and
  // every RUN/BYP/STOP and odd/even change happens at an edge where hi_p is
  // (or becomes) low, so the mode change never cuts a pulse short.
  assign clk_out = (clk & byp_sel) | (hi_p & (hi_n | ~cur_div[0]));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= STOP;
      cnt       <= '0;
      hi_p      <= 1'b0;
      stop_pend <= 1'b0;
      tick      <= 1'b0;
      div_ack   <= 1'b0;
      cur_div   <= SIZE'(RESET_DIV);
    end else begin
      div_ack <= upd;
      if (upd) cur_div <= div_val;
      tick <= 1'b0;

      case (state)
        STOP: begin
          cnt       <= '0;
          hi_p      <= 1'b0;
          stop_pend <= 1'b0;
          if (enable) state <= n_byp ? BYP : RUN;
        end

        RUN: begin
          // hi_p lags cnt by one cycle: the cnt==0 cycle is low and clk_out
          // rises at the end of it, which is also where tick is raised.
          hi_p <= ({1'b0, cnt} < half);
          tick <= (cnt == '0);
          if (!enable) stop_pend <= 1'b1;
          if (wrap) begin
            cnt       <= '0;
            stop_pend <= 1'b0;
            if (stop_now)   state <= STOP;
            else if (n_byp) state <= BYP;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        BYP: begin
          cnt  <= '0;
          hi_p <= 1'b0;
          if (!enable)    state <= STOP;
          else if (!n_byp) state <= RUN;
        end

        default: state <= STOP;
      endcase
    end
  end

  // NOTE: these registers change on the falling edge, i.e. only while clk is
  // low, so gating clk with byp_sel and ANDing with hi_n cannot produce a
  // partial high pulse.
  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      hi_n    <= 1'b0;
      byp_sel <= 1'b0;
    end else begin
      hi_n    <= hi_p;
      byp_sel <= (state == BYP) && enable;
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// ----------------------------------------------------------------------------
// tb_clock_div_prog
//   Directed bench for clock_div_prog. Edge monitors on clk_out record period,
//   high and low widths (in time units; clk period = 10) and the narrowest
//   pulses seen since the last tracker reset. Expected values are computed by
//   hand from the divisor: period = 10*N, high = 5*N.
// ----------------------------------------------------------------------------
module tb_clock_div_prog;

  localparam int SIZE = 8;

  logic            clk;
  logic            resetb;
  logic            enable;
  logic            div_req;
  logic [SIZE-1:0] div_val;
  logic            div_ack;
  logic [SIZE-1:0] cur_div;
  logic            clk_out;
  logic            tick;
  logic            running;

  clock_div_prog #(.SIZE(SIZE), .RESET_DIV(2)) dut (
    .clk     (clk),
    .resetb  (resetb),
    .enable  (enable),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- clk_out edge monitors ----------------
  int     rise_cnt = 0;
  int     tick_cnt = 0;
  longint rise_t   = 0;
  longint fall_t   = 0;
  longint period   = 0;
  longint high_w   = 0;
  longint low_w    = 0;
  longint min_high = 64'd1_000_000;
  longint min_low  = 64'd1_000_000;

  always @(posedge clk_out) begin
    if (rise_cnt > 0) period = longint'($time) - rise_t;
    low_w = longint'($time) - fall_t;
    if (low_w < min_low) min_low = low_w;
    rise_t = longint'($time);
    rise_cnt++;
  end

  always @(negedge clk_out) begin
    high_w = longint'($time) - rise_t;
    if (high_w < min_high) min_high = high_w;
    fall_t = longint'($time);
  end

  always @(negedge clk) if (tick) tick_cnt++;

  task automatic reset_min();
    min_high = 64'd1_000_000;
    min_low  = 64'd1_000_000;
  endtask

  // Wait for n more clk_out rises within a cycle budget.
  task automatic wait_rises(input int n, input int budget, input string tag);
    int target;
    int cyc;
    target = rise_cnt + n;
    cyc    = 0;
    while (rise_cnt < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, longint'(rise_cnt >= target), 1);
  endtask

  // Issue a divisor request and wait for ack; returns cycles to ack.
  task automatic do_req(input logic [SIZE-1:0] v, input string tag, output int cyc);
    @(negedge clk);
    div_req = 1'b1;
    div_val = v;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!div_ack && cyc < 2000);
    check({tag, "_ack"}, longint'(div_ack), 1);
    check({tag, "_cur_div"}, longint'(cur_div), longint'(v));
    div_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, longint'(div_ack), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int     cyc;
    int     rc;
    longint t0;

    resetb  = 1'b1;
    enable  = 1'b0;
    div_req = 1'b0;
    div_val = '0;
    #1 resetb = 1'b0;

    // ---- 1. reset state, default N=2 ----
    repeat (3) @(negedge clk);
    check("rst_clk_out", longint'(clk_out), 0);
    check("rst_tick",    longint'(tick),    0);
    check("rst_ack",     longint'(div_ack), 0);
    check("rst_running", longint'(running), 0);
    check("rst_cur_div", longint'(cur_div), 2);
    resetb = 1'b1;
    repeat (3) @(negedge clk);
    check("stop_running", longint'(running), 0);
    check("stop_clk_out", longint'(clk_out), 0);

    enable = 1'b1;
    @(posedge clk);
    t0 = longint'($time);
    wait_rises(1, 10, "n2_first_rise");
    check("n2_first_latency", rise_t - t0, 10);
    check("n2_running", longint'(running), 1);
    wait_rises(3, 20, "n2_rises");
    check("n2_period", period, 20);
    check("n2_high",   high_w, 10);
    tick_cnt = 0;
    rc = rise_cnt;
    repeat (20) @(negedge clk);
    check("n2_tick_count", longint'(tick_cnt), 10);
    check("n2_rise_count", longint'(rise_cnt - rc), 10);

    // ---- 2. N=5 while running ----
    reset_min();
    do_req(8'd5, "n5", cyc);
    check("n5_ack_at_wrap", longint'(cyc <= 2), 1);
    wait_rises(3, 40, "n5_rises");
    check("n5_period", period, 50);
    check("n5_high",   high_w, 25);
    check("n5_no_runt_high", longint'(min_high >= 10), 1);
    check("n5_no_runt_low",  longint'(min_low  >= 10), 1);

    // ---- 3. N=7 then N=3 requested mid-high ----
    do_req(8'd7, "n7", cyc);
    wait_rises(3, 60, "n7_rises");
    check("n7_period", period, 70);
    check("n7_high",   high_w, 35);
    wait_rises(1, 20, "n7_sync");
    reset_min();
    do_req(8'd3, "n3", cyc);
    check("n3_ack_at_wrap", longint'(cyc <= 7), 1);
    wait_rises(3, 30, "n3_rises");
    check("n3_period", period, 30);
    check("n3_high",   high_w, 15);
    check("n3_no_runt_high", longint'(min_high >= 15), 1);
    check("n3_no_runt_low",  longint'(min_low  >= 15), 1);

    // ---- 4. N=4 -> 1 (bypass) -> 6 ----
    do_req(8'd4, "n4", cyc);
    wait_rises(3, 30, "n4_rises");
    check("n4_period", period, 40);
    check("n4_high",   high_w, 20);
    reset_min();
    do_req(8'd1, "n1", cyc);
    wait_rises(4, 20, "byp_rises");
    check("byp_period",  period, 10);
    check("byp_high",    high_w, 5);
    check("byp_running", longint'(running), 1);
    tick_cnt = 0;
    rc = rise_cnt;
    repeat (10) @(negedge clk);
    check("byp_tick_count", longint'(tick_cnt), 0);
    check("byp_rise_count", longint'(rise_cnt - rc), 10);
    do_req(8'd6, "n6", cyc);
    check("n6_ack_fast", longint'(cyc), 1);
    wait_rises(3, 40, "n6_rises");
    check("n6_period", period, 60);
    check("n6_high",   high_w, 30);
    check("byp_no_runt_high", longint'(min_high >= 5), 1);
    check("byp_no_runt_low",  longint'(min_low  >= 5), 1);

    // ---- 5. enable drop mid-period at N=9 ----
    do_req(8'd9, "n9", cyc);
    wait_rises(3, 60, "n9_rises");
    check("n9_period", period, 90);
    check("n9_high",   high_w, 45);
    wait_rises(1, 20, "n9_sync");
    repeat (2) @(negedge clk);
    enable = 1'b0;
    cyc = 0;
    while (running && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("stop_running_low", longint'(running), 0);
    check("stop_last_high",   high_w, 45);
    check("stop_clk_out_low", longint'(clk_out), 0);
    rc = rise_cnt;
    tick_cnt = 0;
    repeat (20) @(negedge clk);
    check("stop_no_rises", longint'(rise_cnt - rc), 0);
    check("stop_no_ticks", longint'(tick_cnt), 0);

    // ---- 6. N=255 and async reset mid-high ----
    do_req(8'd255, "n255", cyc);
    check("n255_ack_in_stop", longint'(cyc), 1);
    enable = 1'b1;
    wait_rises(3, 1000, "n255_rises");
    check("n255_period", period, 2550);
    check("n255_high",   high_w, 1275);
    wait_rises(1, 300, "n255_sync");
    repeat (10) @(negedge clk);
    check("n255_pre_reset_high", longint'(clk_out), 1);
    #2 resetb = 1'b0;
    #1;
    check("areset_clk_out", longint'(clk_out), 0);
    check("areset_running", longint'(running), 0);
    check("areset_cur_div", longint'(cur_div), 2);
    check("areset_tick",    longint'(tick),    0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
